// File: rtl/mem_access_master_if.sv
// Request and data-memory bus bundle between the core control path, mem_access_master and the data memory.
interface mem_access_master_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  logic              start;
  logic              is_store;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              mem_rm;
  logic              mem_wm;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  start, is_store, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_rm, mem_wm, mem_addr, mem_wdata
  );

  modport slave (
    output start, is_store, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_rm, mem_wm, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_master.sv
// Data-memory initiator: sequences SETUP/ACCESS/HOLD strobes around one load or store at a time.
// Optional MEM_ACCESS_BOUNDS_CHECK_EN rejects requests with addr >= MEM_DEPTH (done+err, no strobe).
module mem_access_master #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned MEM_DEPTH     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_master_if.master bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  if (ACCESS_CYCLES < 1 || MEM_DEPTH < 1) begin : g_bad_cfg
    $error("mem_access_master: ACCESS_CYCLES and MEM_DEPTH must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rm_q, rm_d;
  logic              wm_q, wm_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rm_q     <= 1'b0;
      wm_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rm_q     <= rm_d;
      wm_q     <= wm_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Next state; strobes are set one edge ahead so they are high exactly during ACCESS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    rm_d     = 1'b0;
    wm_d     = 1'b0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
          if (32'(bus.addr) >= MEM_DEPTH) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            op_d     = bus.is_store;
            maddr_d  = bus.addr;
            mwdata_d = bus.wdata;
            busy_d   = 1'b1;
            state_d  = SETUP;
          end
`else
          op_d     = bus.is_store;
          maddr_d  = bus.addr;
          mwdata_d = bus.wdata;
          busy_d   = 1'b1;
          state_d  = SETUP;
`endif
        end
      end
      SETUP: begin
        rm_d    = !op_q;
        wm_d    = op_q;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
          if (!op_q) rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          rm_d  = !op_q;
          wm_d  = op_q;
        end
      end
      HOLD: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_rm    = rm_q;
  assign bus.mem_wm    = wm_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
endmodule
